// File: rtl/mult_rr_arb.sv
// Round-robin arbiter that time-shares one mult_bw signed multiplier among N_REQ
// requesters and returns each full-width product tagged with its requester id.
module mult_rr_arb #(
    parameter int A_DW  = 8,
    parameter int B_DW  = 8,
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*A_DW-1:0]    req_a_i,
    input  logic [N_REQ*B_DW-1:0]    req_b_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [A_DW+B_DW-1:0]     rsp_c_o,
    output logic [1:0]               fsm_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t                      state, state_nxt;
    logic [ID_W-1:0]             ptr, grant_idx, id_q;
    logic                        grant_found;
    logic signed [A_DW-1:0]      op_a, sel_a;
    logic signed [B_DW-1:0]      op_b, sel_b;
    logic signed [A_DW+B_DW-1:0] prod;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and ready may depend combinationally on valid.

    // Search starts one past the last winner so every waiting requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!grant_found && req_valid_i[ID_W'((int'(ptr) + i) % N_REQ)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'((int'(ptr) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == ID_W'(k)) begin
                sel_a = req_a_i[k*A_DW +: A_DW];
                sel_b = req_b_i[k*B_DW +: B_DW];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready_o[grant_idx] = 1'b1;
                    state_nxt              = MUL;
                end
            end
            MUL:     state_nxt = RSP;
            RSP:     if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid_o = (state == RSP);
    assign fsm_state_o = state;

    mult_bw #(.A_DW(A_DW), .B_DW(B_DW)) u_mult (
        .a (op_a),
        .b (op_b),
        .c (prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= ID_W'(N_REQ - 1);
            op_a     <= '0;
            op_b     <= '0;
            id_q     <= '0;
            rsp_id_o <= '0;
            rsp_c_o  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_found) begin
                op_a <= sel_a;
                op_b <= sel_b;
                id_q <= grant_idx;
                ptr  <= grant_idx;
            end
            // Result registers only move here, so they hold steady under backpressure.
            if (state == MUL) begin
                rsp_c_o  <= prod;
                rsp_id_o <= id_q;
            end
        end
    end

endmodule

// Full-width two's-complement multiplier, purely combinational.
module mult_bw #(
    parameter int A_DW = 8,
    parameter int B_DW = 8
) (
    input  logic signed [A_DW-1:0]      a,
    input  logic signed [B_DW-1:0]      b,
    output logic signed [A_DW+B_DW-1:0] c
);

    assign c = (A_DW+B_DW)'(a) * (A_DW+B_DW)'(b);

endmodule

// File: tb/tb_mult_rr_arb.sv
// Directed and randomized bench for mult_rr_arb with a transaction-level round-robin
// model and an expected-response queue.
module tb_mult_rr_arb;

    localparam int A_DW  = 8;
    localparam int B_DW  = 8;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int C_DW  = A_DW + B_DW;
    localparam int N_TX  = 3000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_REQ-1:0]      req_valid_i;
    logic [N_REQ-1:0]      req_ready_o;
    logic [N_REQ*A_DW-1:0] req_a_i;
    logic [N_REQ*B_DW-1:0] req_b_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [ID_W-1:0]       rsp_id_o;
    logic [C_DW-1:0]       rsp_c_o;
    logic [1:0]            fsm_state_o;

    mult_rr_arb #(.A_DW(A_DW), .B_DW(B_DW), .N_REQ(N_REQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_c_o     (rsp_c_o),
        .fsm_state_o (fsm_state_o)
    );

    always #5 clk = ~clk;

    // requester side: one pending operand pair per requester
    bit             act [N_REQ];
    logic [A_DW-1:0] ra [N_REQ];
    logic [B_DW-1:0] rb [N_REQ];

    // reference model: last winner, transaction in flight, cycles since accept
    int  m_ptr;
    bit  m_busy;
    int  m_age;
    logic [ID_W+C_DW-1:0] exp_q[$];

    int n_pass, n_total;
    int n_acc, n_dut_rsp, n_post;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [C_DW-1:0] golden(input logic [A_DW-1:0] a, input logic [B_DW-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[C_DW-1:0];
    endfunction

    function automatic int rr_pick();
        for (int i = 1; i <= N_REQ; i++) begin
            if (act[(m_ptr + i) % N_REQ]) return (m_ptr + i) % N_REQ;
        end
        return -1;
    endfunction

    task automatic apply();
        for (int k = 0; k < N_REQ; k++) begin
            req_valid_i[k]             = act[k];
            req_a_i[k*A_DW +: A_DW]    = ra[k];
            req_b_i[k*B_DW +: B_DW]    = rb[k];
        end
    endtask

    task automatic post(input int k, input logic [A_DW-1:0] a, input logic [B_DW-1:0] b);
        act[k] = 1'b1;
        ra[k]  = a;
        rb[k]  = b;
        apply();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        apply();
        repeat (cycles) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_busy = 1'b0;
        m_ptr  = N_REQ - 1;
        exp_q.delete();
    endtask

    // One clock cycle: check the DUT against the model, then advance the model.
    task automatic step();
        int                   pick;
        logic [N_REQ-1:0]     e_ready;
        bit                   e_valid, acc, done;
        logic [ID_W+C_DW-1:0] e;
        apply();
        #1;
        pick    = m_busy ? -1 : rr_pick();
        e_ready = '0;
        if (pick >= 0) e_ready[pick] = 1'b1;
        e_valid = m_busy && (m_age >= 2);
        chk("req_ready", 32'(req_ready_o), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(e_valid));
        if (e_valid && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("rsp_id", 32'(rsp_id_o), 32'(e[C_DW +: ID_W]));
            chk("rsp_c",  32'(rsp_c_o),  32'(e[C_DW-1:0]));
        end
        if (rsp_valid_o && rsp_ready_i) n_dut_rsp++;
        acc  = (pick >= 0);
        done = e_valid && rsp_ready_i;
        @(posedge clk);
        if (acc) begin
            exp_q.push_back({ID_W'(pick), golden(ra[pick], rb[pick])});
            act[pick] = 1'b0;
            m_busy    = 1'b1;
            m_age     = 1;
            m_ptr     = pick;
            n_acc++;
        end else if (done) begin
            void'(exp_q.pop_front());
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_age++;
        end
        #1;
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < N_REQ; k++) if (act[k]) return 1'b0;
        return !m_busy && exp_q.size() == 0;
    endfunction

    task automatic drain(input string tag, input int budget);
        int g;
        g = 0;
        rsp_ready_i = 1'b1;
        while (!all_idle() && g < budget) begin
            step();
            g++;
        end
        chk(tag, 32'(all_idle()), 32'd1);
    endtask

    logic [A_DW-1:0] cor_a [5] = '{8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF};
    logic [B_DW-1:0] cor_b [5] = '{8'h80, 8'h7F, 8'h7F, 8'h80, 8'hFF};
    logic [C_DW-1:0] cor_c [5] = '{16'h4000, 16'hC080, 16'h3F01, 16'h0000, 16'h0001};
    int              order [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        n_pass = 0; n_total = 0; n_acc = 0; n_dut_rsp = 0; n_post = 0;
        m_age = 0;
        for (int k = 0; k < N_REQ; k++) begin
            act[k] = 1'b0; ra[k] = '0; rb[k] = '0;
        end
        rsp_ready_i = 1'b0;

        // reset values after two reset cycles
        do_reset(2);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_id",    32'(rsp_id_o),    32'd0);
        chk("rst_rsp_c",     32'(rsp_c_o),     32'd0);
        chk("rst_state",     32'(fsm_state_o), 32'd0);

        // single request from requester 1: (-3)*5
        rsp_ready_i = 1'b1;
        post(1, 8'hFD, 8'h05);
        apply(); #1;
        chk("t1_ready", 32'(req_ready_o), 32'b0010);
        step(); step();
        chk("t1_valid", 32'(rsp_valid_o), 32'd1);
        chk("t1_id",    32'(rsp_id_o),    32'd1);
        chk("t1_c",     32'(rsp_c_o),     32'hFFF1);
        step();

        // corner products through requester 0
        for (int i = 0; i < 5; i++) begin
            post(0, cor_a[i], cor_b[i]);
            step(); step();
            chk("corner_c", 32'(rsp_c_o), 32'(cor_c[i]));
            step();
        end

        // full contention from a fresh pointer
        do_reset(1);
        for (int k = 0; k < N_REQ; k++) post(k, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        for (int j = 0; j < 6; j++) begin
            apply(); #1;
            chk("rr_order", 32'(req_ready_o), 32'(1 << order[j]));
            step();
            post(order[j], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            step(); step();
        end
        for (int k = 0; k < N_REQ; k++) act[k] = 1'b0;
        drain("contention_drain", 20);

        // backpressure: response held for five cycles while another request waits
        rsp_ready_i = 1'b0;
        post(2, 8'h9C, 8'h37);
        step(); step();
        post(3, 8'h11, 8'hEE);
        repeat (5) step();
        chk("bp_ready", 32'(req_ready_o), 32'd0);
        chk("bp_valid", 32'(rsp_valid_o), 32'd1);
        chk("bp_c",     32'(rsp_c_o),     32'(golden(8'h9C, 8'h37)));
        rsp_ready_i = 1'b1;
        step();
        chk("bp_idle", 32'(fsm_state_o), 32'd0);
        drain("bp_drain", 20);

        // reset while the multiply is in flight
        post(1, 8'h40, 8'h40);
        step();
        post(0, 8'h05, 8'hF9);
        post(2, 8'h7F, 8'h81);
        do_reset(1);
        chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_state", 32'(fsm_state_o), 32'd0);
        apply(); #1;
        chk("mid_rst_grant", 32'(req_ready_o), 32'b0001);
        drain("mid_rst_drain", 20);

        // randomized sweep with random response backpressure
        n_acc = 0;
        n_dut_rsp = 0;
        for (int cyc = 0; cyc < 40000 && !(n_post >= N_TX && all_idle()); cyc++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!act[k] && n_post < N_TX && $urandom_range(0, 3) == 0) begin
                    post(k, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                    n_post++;
                end
            end
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("sweep_done", 32'(all_idle()), 32'd1);
        chk("sweep_rsp_count", 32'(n_dut_rsp), 32'(n_acc));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
